// File: rtl/cpu_control_unit_if.sv
// cpu_control_unit_if
// Groups the control-unit <-> execution-unit signals.
//   ir, c_flag, n_flag, z_flag : EU -> controller (IR contents, datapath flags)
//   pc_ld .. s_adr, halted     : controller -> EU (control strobes, selects,
//                                ALU opcode, register addresses, halt status)
// Modports: master = control unit, slave = execution unit.
interface cpu_control_unit_if;
  logic [15:0] ir;
  logic        c_flag;
  logic        n_flag;
  logic        z_flag;
  logic        pc_ld;
  logic        pc_inc;
  logic        ir_ld;
  logic        adr_sel;
  logic        reg_w_en;
  logic        mem_w_en;
  logic        s_sel;
  logic [3:0]  alu_op;
  logic [2:0]  w_adr;
  logic [2:0]  r_adr;
  logic [2:0]  s_adr;
  logic        halted;

  modport master (
    input  ir, c_flag, n_flag, z_flag,
    output pc_ld, pc_inc, ir_ld, adr_sel, reg_w_en, mem_w_en, s_sel,
           alu_op, w_adr, r_adr, s_adr, halted
  );

  modport slave (
    output ir, c_flag, n_flag, z_flag,
    input  pc_ld, pc_inc, ir_ld, adr_sel, reg_w_en, mem_w_en, s_sel,
           alu_op, w_adr, r_adr, s_adr, halted
  );
endinterface

// File: rtl/cpu_control_unit.sv
// cpu_control_unit
// Multi-cycle fetch/decode/execute sequencer driving the CPU execution unit.
// Ports:
//   clk    : system clock, rising edge
//   reset  : asynchronous active-low reset
//   bus    : cpu_control_unit_if.master (IR/flags in, control strobes out)
//   step   : single-step advance (only with CPU_CU_SINGLE_STEP_EN defined)
// Optional build macro: CPU_CU_SINGLE_STEP_EN adds the step input and a WAIT
// state entered after RST and after every EXEC state.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// RST       | just out of reset, all outputs 0
// FETCH     | IR <- mem[PC], PC <- PC + 1
// DECODE    | IR valid, pick execute state from opcode
// EX_ALU    | register ALU op, W <- R op S
// EX_LD     | W <- mem[R] through ALU pass-S
// EX_ST     | mem[R] <- S
// EX_BR     | conditional PC <- R through ALU pass-R
// HALT      | stopped until reset
// WAIT      | single-step hold (optional build only)
module cpu_control_unit #(
  parameter logic [3:0] PASS_R_OP = 4'h0,
  parameter logic [3:0] PASS_S_OP = 4'h1
) (
  input  logic                    clk,
  input  logic                    reset,
`ifdef CPU_CU_SINGLE_STEP_EN
  input  logic                    step,
`endif
  cpu_control_unit_if.master      bus
);

  typedef enum logic [3:0] {
    ST_RST    = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_EX_ALU = 4'd3,
    ST_EX_LD  = 4'd4,
    ST_EX_ST  = 4'd5,
    ST_EX_BR  = 4'd6,
    ST_HALT   = 4'd7,
    ST_WAIT   = 4'd8
  } state_t;

  state_t state, state_nxt, after_exec;
  logic   br_taken;

  // Exec states and RST return here; WAIT only exists in the stepping build.
`ifdef CPU_CU_SINGLE_STEP_EN
  assign after_exec = ST_WAIT;
`else
  assign after_exec = ST_FETCH;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_RST;
    else        state <= state_nxt;
  end

  always_comb begin
    br_taken = 1'b0;
    case (bus.ir[11:9])
      3'b000:  br_taken = 1'b1;
      3'b001:  br_taken = bus.z_flag;
      3'b010:  br_taken = bus.n_flag;
      3'b011:  br_taken = bus.c_flag;
      3'b100:  br_taken = !bus.z_flag;
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt    = state;
    bus.pc_ld    = 1'b0;
    bus.pc_inc   = 1'b0;
    bus.ir_ld    = 1'b0;
    bus.adr_sel  = 1'b0;
    bus.reg_w_en = 1'b0;
    bus.mem_w_en = 1'b0;
    bus.s_sel    = 1'b0;
    bus.alu_op   = 4'h0;
    bus.w_adr    = 3'd0;
    bus.r_adr    = 3'd0;
    bus.s_adr    = 3'd0;
    bus.halted   = 1'b0;

    // Register addresses are only presented while executing.
    if (state inside {ST_EX_ALU, ST_EX_LD, ST_EX_ST, ST_EX_BR}) begin
      bus.w_adr = bus.ir[8:6];
      bus.r_adr = bus.ir[5:3];
      bus.s_adr = bus.ir[2:0];
    end

    case (state)
      ST_RST: state_nxt = after_exec;
      ST_FETCH: begin
        bus.ir_ld  = 1'b1;
        bus.pc_inc = 1'b1;
        state_nxt  = ST_DECODE;
      end
      ST_DECODE: begin
        case (bus.ir[15:12])
          4'hC:    state_nxt = ST_EX_LD;
          4'hD:    state_nxt = ST_EX_ST;
          4'hE:    state_nxt = ST_EX_BR;
          4'hF:    state_nxt = ST_HALT;
          default: state_nxt = ST_EX_ALU;
        endcase
      end
      ST_EX_ALU: begin
        bus.alu_op   = bus.ir[15:12];
        bus.reg_w_en = 1'b1;
        state_nxt    = after_exec;
      end
      ST_EX_LD: begin
        bus.adr_sel  = 1'b1;
        bus.s_sel    = 1'b1;
        bus.alu_op   = PASS_S_OP;
        bus.reg_w_en = 1'b1;
        state_nxt    = after_exec;
      end
      ST_EX_ST: begin
        bus.adr_sel  = 1'b1;
        bus.mem_w_en = 1'b1;
        state_nxt    = after_exec;
      end
      ST_EX_BR: begin
        if (br_taken) begin
          bus.alu_op = PASS_R_OP;
          bus.pc_ld  = 1'b1;
        end
        state_nxt = after_exec;
      end
      ST_HALT: bus.halted = 1'b1;
`ifdef CPU_CU_SINGLE_STEP_EN
      ST_WAIT: if (step) state_nxt = ST_FETCH;
`endif
      default: state_nxt = ST_RST;
    endcase
  end

endmodule

// File: tb/tb_cpu_control_unit.sv
module tb_cpu_control_unit;
  logic clk;
  logic reset;
`ifdef CPU_CU_SINGLE_STEP_EN
  logic step;
`endif
  cpu_control_unit_if bus();

  int n_checks;
  int n_fail;

  cpu_control_unit dut (
    .clk   (clk),
    .reset (reset),
`ifdef CPU_CU_SINGLE_STEP_EN
    .step  (step),
`endif
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Field order: pc_ld pc_inc ir_ld adr_sel reg_w_en mem_w_en s_sel
  //              alu_op[3:0] w_adr r_adr s_adr halted
  function automatic logic [20:0] pack(
    input logic pc_ld, input logic pc_inc, input logic ir_ld,
    input logic adr_sel, input logic reg_w_en, input logic mem_w_en,
    input logic s_sel, input logic [3:0] alu_op, input logic [2:0] w,
    input logic [2:0] r, input logic [2:0] s, input logic halted);
    return {pc_ld, pc_inc, ir_ld, adr_sel, reg_w_en, mem_w_en, s_sel,
            alu_op, w, r, s, halted};
  endfunction

  function automatic logic [20:0] obs();
    return {bus.pc_ld, bus.pc_inc, bus.ir_ld, bus.adr_sel, bus.reg_w_en,
            bus.mem_w_en, bus.s_sel, bus.alu_op, bus.w_adr, bus.r_adr,
            bus.s_adr, bus.halted};
  endfunction

  localparam logic [20:0] V_IDLE  = 21'h0;
  localparam logic [20:0] V_FETCH = {1'b0, 1'b1, 1'b1, 18'h0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From an EXEC cycle, advance to the next FETCH (through WAIT when stepping).
  task automatic to_fetch();
    tick();
`ifdef CPU_CU_SINGLE_STEP_EN
    tick();
`endif
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    to_fetch();
  endtask

  task automatic test_reset();
    logic [20:0] v;
    bus.ir = 16'h0000;
    reset = 1'b0;
    tick();
    tick();
    v = obs();
    n_checks++;
    if (v !== V_IDLE) begin
      n_fail++;
      $display("FAIL reset_held: got %h expected %h", v, V_IDLE);
    end
    reset = 1'b1;
    #1;
    v = obs();
    n_checks++;
    if (v !== V_IDLE) begin
      n_fail++;
      $display("FAIL reset_rst_cycle: got %h expected %h", v, V_IDLE);
    end
    to_fetch();
    v = obs();
    n_checks++;
    if (v !== V_FETCH) begin
      n_fail++;
      $display("FAIL reset_fetch: got %h expected %h", v, V_FETCH);
    end
  endtask

  // Runs one instruction from FETCH and checks DECODE, EXEC and the next FETCH.
  task automatic run_instr(input string name, input logic [15:0] ir_val,
                           input logic c, input logic n, input logic z,
                           input logic [20:0] exp_exec);
    logic [20:0] v;
    bus.ir = ir_val;
    bus.c_flag = c;
    bus.n_flag = n;
    bus.z_flag = z;
    tick();
    v = obs();
    n_checks++;
    if (v !== V_IDLE) begin
      n_fail++;
      $display("FAIL %s_decode: got %h expected %h", name, v, V_IDLE);
    end
    tick();
    v = obs();
    n_checks++;
    if (v !== exp_exec) begin
      n_fail++;
      $display("FAIL %s_exec: got %h expected %h", name, v, exp_exec);
    end
    n_checks++;
    if ((bus.pc_ld && bus.pc_inc) || (bus.reg_w_en && bus.mem_w_en)) begin
      n_fail++;
      $display("FAIL %s_invariant: got %h expected exclusive strobes", name, v);
    end
    to_fetch();
    v = obs();
    n_checks++;
    if (v !== V_FETCH) begin
      n_fail++;
      $display("FAIL %s_next_fetch: got %h expected %h", name, v, V_FETCH);
    end
  endtask

  task automatic test_alu();
    run_instr("alu_b", 16'hB0C8, 1'b0, 1'b0, 1'b0,
              pack(0,0,0,0,1,0,0, 4'hB, 3'd3, 3'd1, 3'd0, 0));
    run_instr("alu_0", 16'h0A53, 1'b0, 1'b0, 1'b0,
              pack(0,0,0,0,1,0,0, 4'h0, 3'd1, 3'd2, 3'd3, 0));
  endtask

  task automatic test_load_store();
    run_instr("load", 16'hC0D0, 1'b0, 1'b0, 1'b0,
              pack(0,0,0,1,1,0,1, 4'h1, 3'd3, 3'd2, 3'd0, 0));
    run_instr("store", 16'hD012, 1'b0, 1'b0, 1'b0,
              pack(0,0,0,1,0,1,0, 4'h0, 3'd0, 3'd2, 3'd2, 0));
  endtask

  task automatic test_branch();
    logic [20:0] tk, nt, tk0, nt0;
    tk  = pack(1,0,0,0,0,0,0, 4'h0, 3'd0, 3'd1, 3'd0, 0);
    nt  = pack(0,0,0,0,0,0,0, 4'h0, 3'd0, 3'd1, 3'd0, 0);
    tk0 = pack(1,0,0,0,0,0,0, 4'h0, 3'd0, 3'd0, 3'd0, 0);
    nt0 = V_IDLE;
    run_instr("br_z_taken",   16'hE208, 1'b0, 1'b0, 1'b1, tk);
    run_instr("br_z_not",     16'hE208, 1'b1, 1'b1, 1'b0, nt);
    run_instr("br_always",    16'hE000, 1'b0, 1'b0, 1'b0, tk0);
    run_instr("br_n_taken",   16'hE400, 1'b0, 1'b1, 1'b0, tk0);
    run_instr("br_n_not",     16'hE400, 1'b1, 1'b0, 1'b1, nt0);
    run_instr("br_c_taken",   16'hE600, 1'b1, 1'b0, 1'b0, tk0);
    run_instr("br_c_not",     16'hE600, 1'b0, 1'b1, 1'b1, nt0);
    run_instr("br_nz_taken",  16'hE800, 1'b0, 1'b0, 1'b0, tk0);
    run_instr("br_nz_not",    16'hE800, 1'b0, 1'b0, 1'b1, nt0);
    run_instr("br_never",     16'hEA00, 1'b1, 1'b1, 1'b1, nt0);
    run_instr("br_never7",    16'hEE00, 1'b1, 1'b1, 1'b0, nt0);
  endtask

  task automatic test_reset_mid_store();
    logic [20:0] v;
    bus.ir = 16'hD012;
    tick();
    tick();
    n_checks++;
    if (bus.mem_w_en !== 1'b1) begin
      n_fail++;
      $display("FAIL store_before_reset: got %b expected 1", bus.mem_w_en);
    end
    #1;
    reset = 1'b0;
    #1;
    v = obs();
    n_checks++;
    if (v !== V_IDLE) begin
      n_fail++;
      $display("FAIL store_async_reset: got %h expected %h", v, V_IDLE);
    end
    do_reset();
    v = obs();
    n_checks++;
    if (v !== V_FETCH) begin
      n_fail++;
      $display("FAIL store_reset_refetch: got %h expected %h", v, V_FETCH);
    end
  endtask

  task automatic test_halt();
    logic [20:0] v;
    logic [20:0] vh;
    vh = pack(0,0,0,0,0,0,0, 4'h0, 3'd0, 3'd0, 3'd0, 1);
    bus.ir = 16'hF000;
    tick();
    tick();
    for (int i = 0; i < 12; i++) begin
      v = obs();
      n_checks++;
      if (v !== vh) begin
        n_fail++;
        $display("FAIL halt_hold_%0d: got %h expected %h", i, v, vh);
      end
      if (i == 3) bus.ir = 16'h0000;
      tick();
    end
    do_reset();
    v = obs();
    n_checks++;
    if (v !== V_FETCH) begin
      n_fail++;
      $display("FAIL halt_reset_exit: got %h expected %h", v, V_FETCH);
    end
  endtask

`ifdef CPU_CU_SINGLE_STEP_EN
  task automatic test_single_step();
    logic [20:0] v;
    step = 1'b0;
    bus.ir = 16'hB0C8;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      v = obs();
      n_checks++;
      if (v !== V_IDLE) begin
        n_fail++;
        $display("FAIL step_wait_%0d: got %h expected %h", i, v, V_IDLE);
      end
    end
    step = 1'b1;
    tick();
    step = 1'b0;
    v = obs();
    n_checks++;
    if (v !== V_FETCH) begin
      n_fail++;
      $display("FAIL step_fetch: got %h expected %h", v, V_FETCH);
    end
    tick();
    tick();
    v = obs();
    n_checks++;
    if (v !== pack(0,0,0,0,1,0,0, 4'hB, 3'd3, 3'd1, 3'd0, 0)) begin
      n_fail++;
      $display("FAIL step_exec: got %h expected alu B exec", v);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      v = obs();
      n_checks++;
      if (v !== V_IDLE) begin
        n_fail++;
        $display("FAIL step_rewait_%0d: got %h expected %h", i, v, V_IDLE);
      end
    end
    step = 1'b1;
    tick();
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail = 0;
    reset = 1'b0;
    bus.ir = 16'h0000;
    bus.c_flag = 1'b0;
    bus.n_flag = 1'b0;
    bus.z_flag = 1'b0;
`ifdef CPU_CU_SINGLE_STEP_EN
    step = 1'b1;
`endif
    test_reset();
    test_alu();
    test_load_store();
    test_branch();
    test_reset_mid_store();
    test_halt();
`ifdef CPU_CU_SINGLE_STEP_EN
    test_single_step();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
